// File: rtl/aa_lookup_ctrl.sv
// aa_lookup_ctrl: small associative key/data table shared by two requesters.
// One request is in flight at a time: IDLE grants a requester round-robin,
// SEARCH walks the table one entry per cycle from index 0, and RESP holds the
// result until it is accepted. Table updates commit on SEARCH -> RESP.
module aa_lookup_ctrl #(
  parameter  int ENTRIES = 8,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  localparam int IW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int CW      = $clog2(ENTRIES) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [3:0]          req_op,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic                rsp_exists,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [CW-1:0]       num_entries
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_RESP} state_t;

  localparam logic [1:0] OP_WRITE  = 2'd2;
  localparam logic [1:0] OP_DELETE = 2'd3;

  // Key/data storage carries no reset; valid_q alone defines the contents.
  logic [ADDR_W-1:0] key_mem  [ENTRIES];
  logic [DATA_W-1:0] data_mem [ENTRIES];

  state_t            state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     free_idx_q, free_idx_d;
  logic              free_found_q, free_found_d;
  logic [ADDR_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        op_q, op_d;
  logic              id_q, id_d;
  logic              prio_q, prio_d;
  logic              rsp_exists_q, rsp_exists_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              gnt;
  logic              hit;
  logic              cur_free;
  logic              last_idx;
  logic              mem_we;
  logic              mem_key_we;
  logic [IW-1:0]     mem_addr;

  // Next-state, grant and commit decisions for the IDLE/SEARCH/RESP sequence.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    count_d      = count_q;
    idx_d        = idx_q;
    free_idx_d   = free_idx_q;
    free_found_d = free_found_q;
    key_d        = key_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    id_d         = id_q;
    prio_d       = prio_q;
    rsp_exists_d = rsp_exists_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = 2'b00;
    gnt          = 1'b0;
    mem_we       = 1'b0;
    mem_key_we   = 1'b0;
    mem_addr     = idx_q;
    hit          = valid_q[idx_q] && (key_mem[idx_q] == key_q);
    cur_free     = !valid_q[idx_q];
    last_idx     = (idx_q == IW'(ENTRIES - 1));

    case (state_q)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          // Both valid: favour the one not granted last; else the lone requester.
          gnt            = (req_valid == 2'b11) ? prio_q : req_valid[1];
          req_ready[gnt] = 1'b1;
          id_d           = gnt;
          op_d           = gnt ? req_op[3:2] : req_op[1:0];
          key_d          = gnt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          wdata_d        = gnt ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
          prio_d         = ~gnt;
          idx_d          = '0;
          free_found_d   = 1'b0;
          free_idx_d     = '0;
          state_d        = S_SEARCH;
        end
      end

      S_SEARCH: begin
        if (!free_found_q && cur_free) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (!hit && !last_idx) begin
          idx_d = idx_q + IW'(1);
        end else begin
          state_d      = S_RESP;
          rsp_exists_d = hit;
          rsp_data_d   = hit ? data_mem[idx_q] : '0;
          rsp_err_d    = 1'b0;
          if (op_q == OP_WRITE) begin
            if (hit) begin
              mem_we = 1'b1;
            end else if (free_found_q || cur_free) begin
              mem_addr          = free_found_q ? free_idx_q : idx_q;
              mem_we            = 1'b1;
              mem_key_we        = 1'b1;
              valid_d[mem_addr] = 1'b1;
              count_d           = count_q + CW'(1);
            end else begin
              rsp_err_d = 1'b1;
            end
          end else if (op_q == OP_DELETE && hit) begin
            valid_d[idx_q] = 1'b0;
            count_d        = count_q - CW'(1);
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state and response registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      free_idx_q   <= '0;
      free_found_q <= 1'b0;
      key_q        <= '0;
      wdata_q      <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      prio_q       <= 1'b0;
      rsp_exists_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      free_idx_q   <= free_idx_d;
      free_found_q <= free_found_d;
      key_q        <= key_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      id_q         <= id_d;
      prio_q       <= prio_d;
      rsp_exists_q <= rsp_exists_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Key/data write port; writes only fire on the SEARCH -> RESP commit cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      data_mem[mem_addr] <= wdata_q;
    end
    if (mem_key_we) begin
      key_mem[mem_addr] <= key_q;
    end
  end

  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_id      = id_q;
  assign rsp_exists  = rsp_exists_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign num_entries = count_q;

endmodule

// File: tb/tb_aa_lookup_ctrl.sv
// Directed bench for aa_lookup_ctrl (ENTRIES=8, 32-bit keys and data).
module tb_aa_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic        rsp_exists;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  num_entries;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [1:0] OP_EXISTS = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRITE  = 2'd2;
  localparam logic [1:0] OP_DELETE = 2'd3;

  aa_lookup_ctrl #(.ENTRIES(8), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_exists(rsp_exists), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .num_entries(num_entries)
  );

  always #5 clk = ~clk;

  // Reset sequence; leaves the caller on a falling edge with reset released.
  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full request/response exchange; called on a falling edge.
  task automatic xact(input int r, input logic [1:0] op, input logic [31:0] addr,
                      input logic [31:0] data, output int lat, output logic ex,
                      output logic [31:0] d, output logic er, output logic id,
                      output logic [3:0] num);
    int w;
    req_valid             = 2'b00;
    req_valid[r]          = 1'b1;
    req_op[2*r +: 2]      = op;
    req_addr[32*r +: 32]  = addr;
    req_data[32*r +: 32]  = data;
    w = 0;
    #1;
    while (!req_ready[r] && w < 50) begin
      @(negedge clk); #1; w++;
    end
    lat = 0; ex = 1'bx; d = 'x; er = 1'bx; id = 1'bx; num = 'x;
    if (!req_ready[r]) begin
      vec_cnt++; err_cnt++;
      $display("FAIL xact_grant_timeout req=%0d got req_ready=%b want bit set", r, req_ready);
      req_valid = 2'b00;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    while (!rsp_valid && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) begin
      vec_cnt++; err_cnt++;
      $display("FAIL xact_rsp_timeout got rsp_valid=0 want 1");
      return;
    end
    ex = rsp_exists; d = rsp_data; er = rsp_err; id = rsp_id; num = num_entries;
    $display("xact req=%0d op=%0d addr=%h data=%h -> lat=%0d exists=%b rdata=%h err=%b id=%b num=%0d",
             r, op, addr, data, lat, ex, d, er, id, num);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({req_ready, rsp_valid, rsp_id, rsp_exists, rsp_err} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl got %b want 000000", {req_ready, rsp_valid, rsp_id, rsp_exists, rsp_err});
    end
    vec_cnt++;
    if (rsp_data !== 32'h0 || num_entries !== 4'd0) begin
      err_cnt++;
      $display("FAIL reset_data got data=%h num=%0d want 0/0", rsp_data, num_entries);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exists_miss();
    int lat; logic ex, er, id; logic [31:0] d; logic [3:0] num;
    xact(0, OP_EXISTS, 32'h10, 32'h0, lat, ex, d, er, id, num);
    vec_cnt++;
    if (lat !== 8) begin err_cnt++; $display("FAIL exists_miss_lat got %0d want 8", lat); end
    vec_cnt++;
    if ({ex, er, id} !== 3'b000 || d !== 32'h0) begin
      err_cnt++;
      $display("FAIL exists_miss_rsp got ex/err/id=%b data=%h want 000/0", {ex, er, id}, d);
    end
  endtask

  task automatic test_write_read();
    int lat; logic ex, er, id; logic [31:0] d; logic [3:0] num;
    xact(0, OP_WRITE, 32'h10, 32'hAA, lat, ex, d, er, id, num);
    vec_cnt++;
    if (ex !== 1'b0 || er !== 1'b0 || num !== 4'd1 || lat !== 8) begin
      err_cnt++;
      $display("FAIL write_new got ex=%b err=%b num=%0d lat=%0d want 0/0/1/8", ex, er, num, lat);
    end
    xact(0, OP_READ, 32'h10, 32'h0, lat, ex, d, er, id, num);
    vec_cnt++;
    if (lat !== 1) begin err_cnt++; $display("FAIL read_hit_lat got %0d want 1", lat); end
    vec_cnt++;
    if (ex !== 1'b1 || d !== 32'hAA || er !== 1'b0) begin
      err_cnt++;
      $display("FAIL read_hit_rsp got ex=%b data=%h err=%b want 1/aa/0", ex, d, er);
    end
    xact(0, OP_WRITE, 32'h10, 32'hBB, lat, ex, d, er, id, num);
    vec_cnt++;
    if (ex !== 1'b1 || d !== 32'hAA || num !== 4'd1 || lat !== 1) begin
      err_cnt++;
      $display("FAIL write_hit got ex=%b data=%h num=%0d lat=%0d want 1/aa/1/1", ex, d, num, lat);
    end
    xact(0, OP_READ, 32'h10, 32'h0, lat, ex, d, er, id, num);
    vec_cnt++;
    if (d !== 32'hBB) begin err_cnt++; $display("FAIL read_after_overwrite got %h want bb", d); end
  endtask

  task automatic test_fill();
    int lat; logic ex, er, id; logic [31:0] d; logic [3:0] num;
    logic [31:0] key;
    for (int i = 1; i < 8; i++) begin
      key = 32'h10 * (i + 1);
      xact(0, OP_WRITE, key, 32'h100 + key, lat, ex, d, er, id, num);
      vec_cnt++;
      if (ex !== 1'b0 || num !== 4'(i + 1)) begin
        err_cnt++;
        $display("FAIL fill_%0d got ex=%b num=%0d want 0/%0d", i, ex, num, i + 1);
      end
    end
    xact(0, OP_WRITE, 32'h99, 32'h5, lat, ex, d, er, id, num);
    vec_cnt++;
    if (er !== 1'b1 || ex !== 1'b0 || num !== 4'd8 || d !== 32'h0) begin
      err_cnt++;
      $display("FAIL write_full got err=%b ex=%b num=%0d data=%h want 1/0/8/0", er, ex, num, d);
    end
    xact(0, OP_DELETE, 32'h40, 32'h0, lat, ex, d, er, id, num);
    vec_cnt++;
    if (lat !== 4 || ex !== 1'b1 || d !== 32'h140 || num !== 4'd7 || er !== 1'b0) begin
      err_cnt++;
      $display("FAIL delete_hit got lat=%0d ex=%b data=%h num=%0d err=%b want 4/1/140/7/0",
               lat, ex, d, num, er);
    end
    xact(0, OP_DELETE, 32'h55, 32'h0, lat, ex, d, er, id, num);
    vec_cnt++;
    if (ex !== 1'b0 || num !== 4'd7 || lat !== 8) begin
      err_cnt++;
      $display("FAIL delete_miss got ex=%b num=%0d lat=%0d want 0/7/8", ex, num, lat);
    end
    xact(1, OP_WRITE, 32'hC0, 32'h1C0, lat, ex, d, er, id, num);
    vec_cnt++;
    if (er !== 1'b0 || ex !== 1'b0 || num !== 4'd8 || id !== 1'b1) begin
      err_cnt++;
      $display("FAIL refill got err=%b ex=%b num=%0d id=%b want 0/0/8/1", er, ex, num, id);
    end
    xact(0, OP_READ, 32'hC0, 32'h0, lat, ex, d, er, id, num);
    vec_cnt++;
    if (lat !== 4 || d !== 32'h1C0 || id !== 1'b0) begin
      err_cnt++;
      $display("FAIL refill_slot got lat=%0d data=%h id=%b want 4/1c0/0", lat, d, id);
    end
  endtask

  task automatic test_back_to_back();
    int gcnt = 0;
    int rcnt = 0;
    int cyc  = 0;
    apply_reset();
    req_op    = {OP_EXISTS, OP_EXISTS};
    req_addr  = {32'h2, 32'h1};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    while (rcnt < 4 && cyc < 300) begin
      #1;
      if (req_ready != 2'b00) begin
        vec_cnt++;
        if (req_ready !== (gcnt % 2 == 0 ? 2'b01 : 2'b10)) begin
          err_cnt++;
          $display("FAIL rr_grant_%0d got %b want %b", gcnt, req_ready, (gcnt % 2 == 0) ? 2'b01 : 2'b10);
        end
        $display("grant %0d req_ready=%b", gcnt, req_ready);
        gcnt++;
      end
      if (rsp_valid) begin
        vec_cnt++;
        if (rsp_id !== 1'(rcnt % 2)) begin
          err_cnt++;
          $display("FAIL rr_rsp_id_%0d got %b want %0d", rcnt, rsp_id, rcnt % 2);
        end
        $display("response %0d rsp_id=%b", rcnt, rsp_id);
        rcnt++;
      end
      if (rcnt < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    vec_cnt++;
    if (rcnt != 4) begin err_cnt++; $display("FAIL rr_timeout got %0d responses want 4", rcnt); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    int lat; logic ex, er, id; logic [31:0] d; logic [3:0] num;
    int w = 0;
    xact(0, OP_WRITE, 32'h33, 32'h77, lat, ex, d, er, id, num);
    req_op[1:0]    = OP_READ;
    req_addr[31:0] = 32'h33;
    req_valid      = 2'b01;
    #1;
    while (!req_ready[0] && w < 50) begin @(negedge clk); #1; w++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    w = 0;
    while (!rsp_valid && w < 50) begin @(negedge clk); w++; end
    for (int c = 0; c < 5; c++) begin
      #1;
      vec_cnt++;
      if (rsp_valid !== 1'b1 || rsp_exists !== 1'b1 || rsp_data !== 32'h77 ||
          rsp_id !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 2'b00) begin
        err_cnt++;
        $display("FAIL stall_c%0d got v=%b ex=%b data=%h id=%b err=%b rdy=%b want 1/1/77/0/0/00",
                 c, rsp_valid, rsp_exists, rsp_data, rsp_id, rsp_err, req_ready);
      end
      $display("stall cycle %0d rsp_data=%h req_ready=%b", c, rsp_data, req_ready);
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    vec_cnt++;
    if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_release got rsp_valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_search();
    int lat; logic ex, er, id; logic [31:0] d; logic [3:0] num;
    int w = 0;
    req_op[1:0]      = OP_WRITE;
    req_addr[31:0]   = 32'h44;
    req_data[31:0]   = 32'h99;
    req_valid        = 2'b01;
    #1;
    while (!req_ready[0] && w < 50) begin @(negedge clk); #1; w++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (num_entries !== 4'd0 || rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset got num=%0d rsp_valid=%b want 0/0", num_entries, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(0, OP_EXISTS, 32'h44, 32'h0, lat, ex, d, er, id, num);
    vec_cnt++;
    if (ex !== 1'b0 || num !== 4'd0 || lat !== 8) begin
      err_cnt++;
      $display("FAIL mid_reset_lookup got ex=%b num=%0d lat=%0d want 0/0/8", ex, num, lat);
    end
  endtask

  initial begin
    test_reset();
    test_exists_miss();
    test_write_read();
    test_fill();
    test_back_to_back();
    test_stall();
    test_reset_mid_search();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/aa_lookup_ctrl.md
AA_LOOKUP_CTRL -- requirements
Module: aa_lookup_ctrl

Interface
REQ-001 Parameter ENTRIES, default 8, number of table entries (power of 2, 2..64).
REQ-002 Parameter ADDR_W, default 32, key width.
REQ-003 Parameter DATA_W, default 32, stored data width.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-007 req_ready  output  2  per-requester accept; one-hot or zero.
REQ-008 req_op  input  4  op per requester, bits [2i+1:2i]: 0 EXISTS, 1 READ, 2 WRITE, 3 DELETE.
REQ-009 req_addr  input  2*ADDR_W  key per requester, slice i.
REQ-010 req_data  input  2*DATA_W  write data per requester, slice i.
REQ-011 rsp_valid  output  1  response valid.
REQ-012 rsp_ready  input  1  response accept.
REQ-013 rsp_id  output  1  requester that owns the response.
REQ-014 rsp_exists  output  1  key was present before the op.
REQ-015 rsp_data  output  DATA_W  stored data on hit (READ/EXISTS/DELETE), else 0.
REQ-016 rsp_err  output  1  WRITE miss with table full.
REQ-017 num_entries  output  $clog2(ENTRIES)+1  count of valid entries.

Function
REQ-018 FSM states IDLE, SEARCH, RESP; one request in flight at a time.
REQ-019 IDLE: req_ready asserted combinationally for the granted requester only when state is IDLE; transfer = req_valid[i] & req_ready[i]; key, op, data, id captured; next state SEARCH.
REQ-020 Arbitration round-robin: with both valid, grant the requester not granted last; with one valid, grant it; after reset requester 0 has priority.
REQ-021 SEARCH: one entry compared per cycle, index 0 upward; a hit on valid entry with equal key ends search at that index; a miss ends after index ENTRIES-1.
REQ-022 Search latency: hit at index k takes k+1 SEARCH cycles; miss takes ENTRIES cycles; rsp_valid rises the cycle after the last SEARCH cycle.
REQ-023 During SEARCH the lowest-index invalid entry is recorded as the allocation slot.
REQ-024 EXISTS: no table change; READ: no table change; both return rsp_exists and rsp_data.
REQ-025 WRITE hit: data overwritten in place, rsp_exists=1, rsp_data = old data.
REQ-026 WRITE miss with free slot: key/data stored in lowest free slot, valid set, num_entries+1, rsp_exists=0.
REQ-027 WRITE miss, table full: no change, rsp_err=1, rsp_exists=0.
REQ-028 DELETE hit: valid cleared, num_entries-1, rsp_exists=1, rsp_data = deleted data; DELETE miss: no change, rsp_exists=0.
REQ-029 Table updates commit on the transition SEARCH->RESP.
REQ-030 RESP: rsp_* held stable while rsp_valid & !rsp_ready; on rsp_ready return to IDLE; new request acceptable the cycle after the handshake.
REQ-031 rsp_err is 0 for all ops other than WRITE.
REQ-032 num_entries never exceeds ENTRIES nor underflows below 0.

Reset
REQ-033 rst_n low asynchronously: state IDLE, all valid bits 0, num_entries 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_exists 0, rsp_data 0, rsp_err 0, round-robin priority to requester 0.
REQ-034 Reset in SEARCH or RESP aborts the op with no table commit; the response is lost.
REQ-035 Key/data storage needs no reset; only valid bits define contents.

Verification
REQ-036 Reset, EXISTS addr 0x10 from req 0 -> after 8 SEARCH cycles rsp_exists=0, rsp_data=0, rsp_id=0.
REQ-037 WRITE 0x10/0xAA then READ 0x10 -> first rsp_exists=0, num_entries=1; second hits at index 0 after 1 SEARCH cycle, rsp_exists=1, rsp_data=0xAA.
REQ-038 Fill 8 distinct keys, 9th WRITE -> rsp_err=1, num_entries=8; DELETE key in slot 3 then WRITE new key -> lands in slot 3, num_entries=8, rsp_err=0.
REQ-039 Both requesters valid continuously -> grants alternate 0,1,0,1; rsp_id matches grant order.
REQ-040 rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout.
REQ-041 rst_n asserted mid-SEARCH of a WRITE -> num_entries=0, subsequent EXISTS of that key returns rsp_exists=0.
